// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg : shared defaults and types for the decode-stage register file
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    localparam int RF_DW    = 32;
    localparam int RF_AW    = 4;
    localparam int RF_DEPTH = 16;
    localparam int RF_OPW   = 4;

    typedef logic [RF_OPW-1:0] opcode_t;

    localparam logic [RF_AW-1:0] ZERO_ADDR = '0;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if : decode-side bus of the register file (reads, writeback, issue)
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface regfile_sb_if #(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int NUM_RD = 2,
    parameter int OPW    = 4
);

    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_busy;
    logic                 stall;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_dst;
    logic [OPW-1:0]       opcode_in;
    logic [AW-1:0]        regdst_in;
    logic [OPW-1:0]       opcode_out;
    logic [AW-1:0]        regdst_out;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_dst, opcode_in, regdst_in,
        input  rd_data, rd_busy, stall, opcode_out, regdst_out
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_dst, opcode_in, regdst_in,
        output rd_data, rd_busy, stall, opcode_out, regdst_out
    );

endinterface : regfile_sb_if

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ---------------------------------------------------------------------------
// regfile_rd_port : one combinational read port with writeback bypass,
//                   zero-register force and busy lookup
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 4,
    parameter int DEPTH    = 16,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic [AW-1:0]    rd_addr_i,
    input  logic [DW-1:0]    mem_i [DEPTH],
    input  logic [DEPTH-1:0] busy_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [DW-1:0]    wr_data_i,
    output logic [DW-1:0]    rd_data_o,
    output logic             rd_busy_o
);

    logic w_hit;
    logic w_is_zero;

    assign w_hit     = wr_en_i && (wr_addr_i == rd_addr_i);
    assign w_is_zero = ZERO_REG && (rd_addr_i == AW'(ZERO_ADDR));

    // Zero force has the last word so a bypassed write to r0 never leaks through.
    always_comb begin
        rd_data_o = mem_i[rd_addr_i];
        if (w_hit) begin
            rd_data_o = wr_data_i;
        end
        if (w_is_zero) begin
            rd_data_o = '0;
        end
    end

    assign rd_busy_o = busy_i[rd_addr_i] && !w_hit && !w_is_zero;

endmodule : regfile_rd_port

`default_nettype wire

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb : multi-read-port register file with bypass, busy scoreboard
//              and a one-cycle opcode/destination pipeline stage
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = RF_AW,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b0,
    parameter int OPW      = RF_OPW
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    if (DEPTH != (1 << AW)) begin : g_bad_depth
        $error("regfile_sb: DEPTH must equal 2**AW");
    end
    if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
        $error("regfile_sb: NUM_RD must be in 1..4");
    end

    logic [DW-1:0]        mem_q [DEPTH];
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;
    logic [OPW-1:0]       opcode_q;
    logic [AW-1:0]        regdst_q;

    logic                 w_wr_ok;
    logic                 w_iss_ok;
    logic [DW-1:0]        w_rd_data [NUM_RD];
    logic [NUM_RD-1:0]    w_rd_busy;
    logic [NUM_RD*DW-1:0] w_rd_data_flat;

    assign w_wr_ok  = bus.wr_en  && !(ZERO_REG && (bus.wr_addr == AW'(ZERO_ADDR)));
    assign w_iss_ok = bus.iss_en && !(ZERO_REG && (bus.iss_dst == AW'(ZERO_ADDR)));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (w_wr_ok) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Issue is applied after writeback so a same-cycle new producer keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (w_wr_ok) begin
            busy_d[bus.wr_addr] = 1'b0;
        end
        if (w_iss_ok) begin
            busy_d[bus.iss_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            opcode_q <= '0;
            regdst_q <= '0;
        end else begin
            busy_q   <= busy_d;
            opcode_q <= bus.opcode_in;
            regdst_q <= bus.regdst_in;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
        regfile_rd_port #(
            .DW       (DW),
            .AW       (AW),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .rd_addr_i (bus.rd_addr[i*AW +: AW]),
            .mem_i     (mem_q),
            .busy_i    (busy_q),
            .wr_en_i   (bus.wr_en),
            .wr_addr_i (bus.wr_addr),
            .wr_data_i (bus.wr_data),
            .rd_data_o (w_rd_data[i]),
            .rd_busy_o (w_rd_busy[i])
        );
    end

    always_comb begin
        w_rd_data_flat = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_data_flat[i*DW +: DW] = w_rd_data[i];
        end
    end

    assign bus.rd_data    = w_rd_data_flat;
    assign bus.rd_busy    = w_rd_busy;
    assign bus.stall      = |w_rd_busy;
    assign bus.opcode_out = opcode_q;
    assign bus.regdst_out = regdst_q;

endmodule : regfile_sb

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb : directed scoreboard bench for regfile_sb (ZERO_REG=1 and =0)
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.DW(32), .AW(4), .NUM_RD(2), .OPW(4)) ifa ();
    regfile_sb_if #(.DW(32), .AW(4), .NUM_RD(2), .OPW(4)) ifb ();

    assign ifb.rd_addr   = ifa.rd_addr;
    assign ifb.wr_en     = ifa.wr_en;
    assign ifb.wr_addr   = ifa.wr_addr;
    assign ifb.wr_data   = ifa.wr_data;
    assign ifb.iss_en    = ifa.iss_en;
    assign ifb.iss_dst   = ifa.iss_dst;
    assign ifb.opcode_in = ifa.opcode_in;
    assign ifb.regdst_in = ifa.regdst_in;

    regfile_sb #(.DW(32), .DEPTH(16), .AW(4), .NUM_RD(2), .ZERO_REG(1'b1), .OPW(4)) u_dut_z1 (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    regfile_sb #(.DW(32), .DEPTH(16), .AW(4), .NUM_RD(2), .ZERO_REG(1'b0), .OPW(4)) u_dut_z0 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  busy;
        logic        stall;
    } exp_rd_t;

    exp_rd_t     q_rd [$];
    logic [7:0]  q_pipe [$];

    logic [31:0] m_mem  [2][16];
    logic        m_busy [2][16];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_data(input int z, input logic [3:0] a);
        if (z == 1 && a == 4'd0) return 32'h0;
        if (ifa.wr_en && ifa.wr_addr == a) return ifa.wr_data;
        return m_mem[z][a];
    endfunction

    function automatic logic exp_busy(input int z, input logic [3:0] a);
        if (z == 1 && a == 4'd0) return 1'b0;
        return m_busy[z][a] && !(ifa.wr_en && ifa.wr_addr == a);
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int k = 0; k < 16; k++) begin
                m_mem[z][k]  = '0;
                m_busy[z][k] = 1'b0;
            end
    endtask

    task automatic step(input string tag, input logic r,
                        input logic [3:0] ra0, input logic [3:0] ra1,
                        input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic ie, input logic [3:0] id,
                        input opcode_t op, input logic [3:0] rdst);
        exp_rd_t e;
        exp_rd_t o;
        logic [7:0] ep;
        @(negedge clk);
        rst           = r;
        ifa.rd_addr   = {ra1, ra0};
        ifa.wr_en     = we;
        ifa.wr_addr   = wa;
        ifa.wr_data   = wd;
        ifa.iss_en    = ie;
        ifa.iss_dst   = id;
        ifa.opcode_in = op;
        ifa.regdst_in = rdst;
        q_pipe.push_back(r ? 8'h00 : {op, rdst});
        #1;
        for (int z = 0; z < 2; z++) begin
            e.data  = {exp_data(z, ra1), exp_data(z, ra0)};
            e.busy  = {exp_busy(z, ra1), exp_busy(z, ra0)};
            e.stall = |e.busy;
            q_rd.push_back(e);
        end
        for (int z = 0; z < 2; z++) begin
            e = q_rd.pop_front();
            if (z == 0) begin
                o.data = ifb.rd_data; o.busy = ifb.rd_busy; o.stall = ifb.stall;
            end else begin
                o.data = ifa.rd_data; o.busy = ifa.rd_busy; o.stall = ifa.stall;
            end
            chk($sformatf("%s z%0d rd_data", tag, z), o.data, e.data);
            chk($sformatf("%s z%0d rd_busy", tag, z), 64'(o.busy), 64'(e.busy));
            chk($sformatf("%s z%0d stall", tag, z), 64'(o.stall), 64'(e.stall));
        end
        @(posedge clk);
        for (int z = 0; z < 2; z++) begin
            if (r) begin
                for (int k = 0; k < 16; k++) begin
                    m_mem[z][k] = '0; m_busy[z][k] = 1'b0;
                end
            end else begin
                if (we && !(z == 1 && wa == 4'd0)) begin
                    m_mem[z][wa] = wd; m_busy[z][wa] = 1'b0;
                end
                if (ie && !(z == 1 && id == 4'd0)) m_busy[z][id] = 1'b1;
            end
        end
        #1;
        ep = q_pipe.pop_front();
        chk({tag, " opcode_out"}, 64'(ifa.opcode_out), 64'(ep[7:4]));
        chk({tag, " regdst_out"}, 64'(ifa.regdst_out), 64'(ep[3:0]));
    endtask

    initial begin
        rst = 1'b1;
        ifa.rd_addr = '0; ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
        ifa.iss_en = 1'b0; ifa.iss_dst = '0; ifa.opcode_in = '0; ifa.regdst_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset opcode_out", 64'(ifa.opcode_out), 64'h0);
        chk("reset regdst_out", 64'(ifa.regdst_out), 64'h0);

        for (int a = 0; a < 16; a++)
            step("reset_read", 1'b0, 4'(a), 4'(15 - a), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'(a), 4'(15 - a));

        step("bypass_r5", 1'b0, 4'd5, 4'd1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'h3, 4'd5);
        step("hold_r5",   1'b0, 4'd5, 4'd5, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'h4, 4'd6);

        step("issue_r3",  1'b0, 4'd0, 4'd4, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'h5, 4'd3);
        step("busy_r3",   1'b0, 4'd4, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'h6, 4'd3);
        step("wb_r3",     1'b0, 4'd4, 4'd3, 1'b1, 4'd3, 32'h12, 1'b0, 4'd0, 4'h7, 4'd3);
        step("clear_r3",  1'b0, 4'd3, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'h8, 4'd3);

        step("wb_iss_r7", 1'b0, 4'd2, 4'd5, 1'b1, 4'd7, 32'h1, 1'b1, 4'd7, 4'h9, 4'd7);
        step("read_r7",   1'b0, 4'd7, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'hB, 4'd7);

        step("wb_iss_r0", 1'b0, 4'd0, 4'd3, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b1, 4'd0, 4'hC, 4'd0);
        step("read_r0",   1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'hD, 4'd0);

        step("prep_r2",   1'b0, 4'd2, 4'd7, 1'b1, 4'd2, 32'h99, 1'b1, 4'd2, 4'hE, 4'd2);
        step("rst_r2",    1'b1, 4'd2, 4'd7, 1'b1, 4'd2, 32'h55, 1'b1, 4'd2, 4'hF, 4'd2);
        step("after_rst", 1'b0, 4'd2, 4'd7, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'hA, 4'd9);
        step("opcode_a",  1'b0, 4'd5, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'h1, 4'd1);

        for (int n = 0; n < 24; n++)
            step("random", 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_regfile_sb

`default_nettype wire
